// File: rtl/conv_output_buffer.sv
// Output FIFO between the convolution controller and the host: captures every
// finished pixel, presents it over valid/ready, and tracks stall, overflow and layer completion.
module conv_output_buffer #(
  parameter int DATA_WIDTH         = 32,
  parameter int COORD_WIDTH        = 32,
  parameter int DEPTH              = 16,
  parameter int ALMOST_FULL_MARGIN = 4,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64
) (
  input  logic                     clk,
  input  logic                     arst_n_in,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic [COORD_WIDTH-1:0]   in_x,
  input  logic [COORD_WIDTH-1:0]   in_y,
  input  logic [COORD_WIDTH-1:0]   in_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [COORD_WIDTH-1:0]   out_x,
  output logic [COORD_WIDTH-1:0]   out_y,
  output logic [COORD_WIDTH-1:0]   out_ch,
  output logic                     stall_req,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [LW-1:0] MARGIN_L = LW'(ALMOST_FULL_MARGIN);
  localparam logic [31:0]   TOTAL_L  =
    32'(FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS);

  logic [DATA_WIDTH-1:0]  mem_data_r [DEPTH];
  logic [COORD_WIDTH-1:0] mem_x_r    [DEPTH];
  logic [COORD_WIDTH-1:0] mem_y_r    [DEPTH];
  logic [COORD_WIDTH-1:0] mem_ch_r   [DEPTH];

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] fill_r;
  logic [31:0]   pop_cnt_r;
  logic          overflow_r;
  logic          done_r;

  logic full_s;
  logic pop_s;
  logic push_s;
  logic drop_s;

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign full_s = (fill_r == DEPTH_L);
  assign pop_s  = out_valid && out_ready;
  assign push_s = in_valid && (!full_s || pop_s);
  assign drop_s = in_valid && full_s && !pop_s;

  assign out_valid  = (fill_r != {LW{1'b0}});
  assign out_data   = mem_data_r[rd_ptr_r];
  assign out_x      = mem_x_r[rd_ptr_r];
  assign out_y      = mem_y_r[rd_ptr_r];
  assign out_ch     = mem_ch_r[rd_ptr_r];
  assign stall_req  = ((DEPTH_L - fill_r) <= MARGIN_L);
  assign overflow   = overflow_r;
  assign fill_level = fill_r;
  assign done       = done_r;

  // Entry storage; start leaves contents in place since out_valid hides them.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_r[i] <= '0;
        mem_x_r[i]    <= '0;
        mem_y_r[i]    <= '0;
        mem_ch_r[i]   <= '0;
      end
    end else if (push_s && !start) begin
      mem_data_r[wr_ptr_r] <= in_data;
      mem_x_r[wr_ptr_r]    <= in_x;
      mem_y_r[wr_ptr_r]    <= in_y;
      mem_ch_r[wr_ptr_r]   <= in_ch;
    end else begin
      mem_data_r[wr_ptr_r] <= mem_data_r[wr_ptr_r];
    end
  end

  // Pointers, occupancy, sticky overflow, saturating pop counter and done flag.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fill_r     <= '0;
      pop_cnt_r  <= 32'd0;
      overflow_r <= 1'b0;
      done_r     <= 1'b0;
    end else if (start) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fill_r     <= '0;
      pop_cnt_r  <= 32'd0;
      overflow_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   fill_r <= fill_r + LW'(1);
        2'b01:   fill_r <= fill_r - LW'(1);
        default: fill_r <= fill_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
      if (pop_s && (pop_cnt_r != TOTAL_L)) begin
        pop_cnt_r <= pop_cnt_r + 32'd1;
      end else begin
        pop_cnt_r <= pop_cnt_r;
      end
      if (pop_s && (pop_cnt_r == TOTAL_L - 32'd1)) begin
        done_r <= 1'b1;
      end else begin
        done_r <= done_r;
      end
    end
  end

endmodule

// File: tb/tb_conv_output_buffer.sv
// Directed bench for conv_output_buffer with a 2x2x2 layer (TOTAL=8) and a 16-deep FIFO.
module tb_conv_output_buffer;

  logic        clk;
  logic        arst_n_in;
  logic        start;
  logic        in_valid;
  logic [31:0] in_data;
  logic [31:0] in_x;
  logic [31:0] in_y;
  logic [31:0] in_ch;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] out_x;
  logic [31:0] out_y;
  logic [31:0] out_ch;
  logic        stall_req;
  logic        overflow;
  logic [4:0]  fill_level;
  logic        done;

  int total;
  int bad;

  conv_output_buffer #(
    .DATA_WIDTH(32), .COORD_WIDTH(32), .DEPTH(16), .ALMOST_FULL_MARGIN(4),
    .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2), .OUTPUT_NB_CHANNELS(2)
  ) dut (
    .clk(clk), .arst_n_in(arst_n_in), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_x(in_x), .in_y(in_y), .in_ch(in_ch),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_x(out_x), .out_y(out_y), .out_ch(out_ch),
    .stall_req(stall_req), .overflow(overflow), .fill_level(fill_level), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0; bad = 0;
    arst_n_in = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = 32'd0; in_x = 32'd0; in_y = 32'd0; in_ch = 32'd0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_fill", 32'(fill_level), 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    #9 arst_n_in = 1'b1;
    tick();

    // single push then pop
    in_valid = 1'b1; in_data = 32'h1234; in_x = 32'd3; in_y = 32'd5; in_ch = 32'd7;
    tick();
    in_valid = 1'b0;
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", out_data, 32'h1234);
    chk("single_x", out_x, 32'd3);
    chk("single_y", out_y, 32'd5);
    chk("single_ch", out_ch, 32'd7);
    chk("single_fill", 32'(fill_level), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("single_pop_valid", 32'(out_valid), 32'd0);
    chk("single_pop_fill", 32'(fill_level), 32'd0);

    // burst with continuous ready
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      tick();
      chk("burst_valid", 32'(out_valid), 32'd1);
      chk("burst_data", out_data, 32'(i));
      chk("burst_fill", 32'(fill_level), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("burst_end_fill", 32'(fill_level), 32'd0);

    // fill, stall, overflow, drain
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 32'(100 + i);
      tick();
      chk("fill_level", 32'(fill_level), 32'(i + 1));
      chk("fill_stall", 32'(stall_req), (i + 1 >= 12) ? 32'd1 : 32'd0);
      chk("fill_overflow", 32'(overflow), 32'd0);
    end
    in_data = 32'd999;
    tick();
    in_valid = 1'b0;
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_fill", 32'(fill_level), 32'd16);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_data", out_data, 32'(100 + i));
      tick();
    end
    out_ready = 1'b0;
    chk("drain_empty", 32'(out_valid), 32'd0);
    chk("drain_ovf_held", 32'(overflow), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_clr_ovf", 32'(overflow), 32'd0);

    // push+pop while full
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 32'(200 + i);
      tick();
    end
    chk("full_fill", 32'(fill_level), 32'd16);
    in_data = 32'd300; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("pp_fill", 32'(fill_level), 32'd16);
    chk("pp_ovf", 32'(overflow), 32'd0);
    chk("pp_head", out_data, 32'd201);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("pp_order", out_data, (i < 15) ? 32'(201 + i) : 32'd300);
      tick();
    end
    out_ready = 1'b0;
    chk("pp_empty_fill", 32'(fill_level), 32'd0);

    // start with a concurrent in_valid: cleared, push ignored
    start = 1'b1; in_valid = 1'b1; in_data = 32'd77;
    tick();
    start = 1'b0; in_valid = 1'b0;
    chk("start_push_fill", 32'(fill_level), 32'd0);
    chk("start_push_valid", 32'(out_valid), 32'd0);
    chk("start_push_ovf", 32'(overflow), 32'd0);
    chk("start_done", 32'(done), 32'd0);

    // done after TOTAL=8 pops
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("done_before_last", 32'(done), 32'd0);
    tick();
    out_ready = 1'b0;
    chk("done_set", 32'(done), 32'd1);
    chk("done_fill", 32'(fill_level), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_clr", 32'(done), 32'd0);
    chk("done_clr_fill", 32'(fill_level), 32'd0);
    chk("done_clr_ovf", 32'(overflow), 32'd0);

    // asynchronous reset with 5 entries buffered
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 32'(50 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("prerst_fill", 32'(fill_level), 32'd5);
    #2 arst_n_in = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_fill", 32'(fill_level), 32'd0);
    chk("arst_stall", 32'(stall_req), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_data", out_data, 32'd0);
    #3 arst_n_in = 1'b1;
    tick();
    chk("post_rst_fill", 32'(fill_level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_output_buffer.md
Name: conv_output_buffer

Overview:
- Sits directly downstream of the convolution controller/datapath pair.
- The controller emits one finished output pixel per valid pulse (output_valid, x, y, ch, accumulated data) and cannot be back-pressured.
- This block captures every result in a FIFO and presents it to the host over a valid/ready handshake.
- It also raises an early-warning stall request, flags overflow, and signals completion once every expected output has been drained.

Parameters:
- DATA_WIDTH, 32, width of the accumulated output value.
- COORD_WIDTH, 32, width of each of x, y, ch.
- DEPTH, 16, number of FIFO entries; power of two, >= 4.
- ALMOST_FULL_MARGIN, 4, stall_req asserts when free entries <= this value.
- FEATURE_MAP_WIDTH, 1024, output width in pixels.
- FEATURE_MAP_HEIGHT, 1024, output height in pixels.
- OUTPUT_NB_CHANNELS, 64, output channels per pixel.

Ports:
- clk  in  1  clock.
- arst_n_in  in  1  asynchronous reset, active low.
- start  in  1  one-cycle pulse; clears the buffer and counters for a new layer.
- in_valid  in  1  upstream result valid; single-cycle pulses, no ready.
- in_data  in  DATA_WIDTH  result value.
- in_x  in  COORD_WIDTH  result x.
- in_y  in  COORD_WIDTH  result y.
- in_ch  in  COORD_WIDTH  result output channel.
- out_valid  out  1  head entry available.
- out_ready  in  1  host accepts head entry.
- out_data  out  DATA_WIDTH  head value.
- out_x  out  COORD_WIDTH  head x.
- out_y  out  COORD_WIDTH  head y.
- out_ch  out  COORD_WIDTH  head channel.
- stall_req  out  1  free entries <= ALMOST_FULL_MARGIN.
- overflow  out  1  sticky; a result was dropped.
- fill_level  out  $clog2(DEPTH)+1  current occupancy.
- done  out  1  level; all TOTAL outputs popped.

Behaviour:
- Reset (arst_n_in=0, async): rd/wr pointers=0, fill_level=0, out_valid=0, out_data/out_x/out_y/out_ch=0, stall_req=0, overflow=0, done=0, pop counter=0.
- Register file: DEPTH entries of {data, x, y, ch}. Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0.
- Push:
  - Occurs on a clk edge with in_valid=1 and (not full, or pop in the same cycle).
  - Writes the entry at wr_ptr, then wr_ptr+1.
- Pop:
  - Occurs on a clk edge with out_valid && out_ready; rd_ptr+1.
  - out_ready with out_valid=0 has no effect.
- Output path: out_* is driven from the entry at rd_ptr (registered storage, combinational read); out_valid = (fill_level != 0).
- Latency: an entry pushed at edge N appears with out_valid=1 in the cycle after N (1 cycle, empty FIFO). Order is strict FIFO.
- Simultaneous push+pop:
  - Both occur; fill_level unchanged. This includes the full case, where the push is accepted because a slot frees the same edge.
  - On empty, only a push is possible, since out_valid=0.
- Full, push without pop: entry dropped, pointers unchanged, overflow set to 1 and held until start or reset.
- stall_req: combinational from fill_level, equal to (DEPTH - fill_level) <= ALMOST_FULL_MARGIN. Advisory only; the block never back-pressures in_valid.
- Pop counter and done:
  - 32-bit pop counter increments on each pop.
  - TOTAL = FEATURE_MAP_WIDTH*FEATURE_MAP_HEIGHT*OUTPUT_NB_CHANNELS.
  - done=1 from the cycle after the pop that makes count==TOTAL, held until start/reset.
  - Further pops after done still drain the FIFO and saturate the counter at TOTAL.
- start (synchronous, highest priority): pointers, fill_level, overflow, done, and pop counter are cleared at the edge.
  - An in_valid or pop in the same cycle is ignored and not counted as overflow.
  - Storage contents are not cleared; out_valid=0 hides them.
- Reset mid-operation: all state returns to reset values immediately; buffered entries are lost.
- No state machine beyond FIFO occupancy plus a done flag. Implementation uses a fill counter, not the pointer-MSB trick.

Test Plan:
- Single push: in_valid=1 for 1 cycle with data=0x1234, x=3, y=5, ch=7, out_ready=0.
  - Required: next cycle out_valid=1, out_*={0x1234,3,5,7}, fill_level=1.
  - Then out_ready=1 for one cycle -> out_valid=0, fill_level=0.
- Burst ordering with DEPTH=16: push 10 entries with data=i on consecutive cycles while out_ready=1 continuously.
  - Required: data 0..9 emitted in order, no gaps after the first, fill_level never exceeds 1.
- Fill and overflow: out_ready=0, push 17 entries.
  - Required: stall_req rises when fill_level reaches 12, and fill_level=16 after push 16.
  - Required: on push 17, overflow=1 and the entry is dropped.
  - Then drain: exactly data 0..15 come out; overflow stays 1 until start.
- Push+pop when full: fill to 16, then in_valid=1 and out_ready=1 in the same cycle.
  - Required: fill_level stays 16, overflow stays 0, the head advances, and the new entry is last in order.
- Done with FEATURE_MAP_WIDTH=2, FEATURE_MAP_HEIGHT=2, OUTPUT_NB_CHANNELS=2 (TOTAL=8): push and pop 8 entries.
  - Required: done=1 in the cycle after the 8th pop.
  - Then a start pulse -> done=0, fill_level=0, overflow=0.
- Async reset while 5 entries are buffered: pulse arst_n_in low mid-cycle.
  - Required: out_valid=0, fill_level=0, and stall_req/overflow/done=0 immediately, without waiting for a clk edge.
